// File: rtl/serial_arith_pkg.sv
// Shared types and helpers for the digit-serial arithmetic blocks.
package serial_arith_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Counter width for n digits; never narrower than one bit so N=1 still has a counter.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/digit_adder.sv
// Combinational DIGIT-bit ripple adder; c_msb exposes the carry into the top bit for overflow.
module digit_adder #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  logic c;

  always_comb begin
    sum   = '0;
    c_msb = 1'b0;
    c     = cin;
    for (int i = 0; i < DIGIT; i++) begin
      if (i == DIGIT - 1) c_msb = c;
      sum[i] = a[i] ^ b[i] ^ c;
      c      = (a[i] & b[i]) | (a[i] & c) | (b[i] & c);
    end
    cout = c;
  end

endmodule

// File: rtl/serial_addsub.sv
// Digit-serial adder/subtractor: DIGIT bits per enabled cycle, LSB first, with handshake.
//   state   | meaning
//   IDLE    | waiting for start
//   RUN     | one digit per enabled cycle, N = WIDTH/DIGIT cycles
//   DONE    | result final, done pulses; start here chains the next operation
module serial_addsub
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic [DIGIT-1:0] s_digit,
  output logic             s_valid,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = cnt_width(N);

  if ((WIDTH < 2) || (DIGIT < 1) || ((WIDTH % DIGIT) != 0)) begin : g_bad_param
    $error("serial_addsub: DIGIT must divide WIDTH and WIDTH must be >= 2");
  end

  state_t           state_q;
  logic [WIDTH-1:0] opa_q, opb_q, sum_q;
  logic             carry_q, cout_q, ovf_q;
  logic [CW-1:0]    cnt_q;

  logic [DIGIT-1:0]       dsum;
  logic                   dcout, dcmsb;
  logic                   last;
  logic [WIDTH+DIGIT-1:0] sum_cat;
  logic [WIDTH-1:0]       sum_d;

  digit_adder #(.DIGIT(DIGIT)) u_digit_adder (
    .a    (opa_q[DIGIT-1:0]),
    .b    (opb_q[DIGIT-1:0]),
    .cin  (carry_q),
    .sum  (dsum),
    .cout (dcout),
    .c_msb(dcmsb)
  );

  assign last = (cnt_q == CW'(N - 1));

  // New digit enters at the MSB end so the result is LSB-aligned after N shifts.
  assign sum_cat = {dsum, sum_q};
  assign sum_d   = sum_cat[WIDTH+DIGIT-1:DIGIT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else if (en) begin
      case (state_q)
        ST_RUN: begin
          opa_q   <= opa_q >> DIGIT;
          opb_q   <= opb_q >> DIGIT;
          carry_q <= dcout;
          sum_q   <= sum_d;
          cnt_q   <= cnt_q + 1'b1;
          if (last) begin
            state_q <= ST_DONE;
            cnt_q   <= '0;
            cout_q  <= dcout;
            ovf_q   <= dcout ^ dcmsb;
          end
        end
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_q <= ST_RUN;
            opa_q   <= a;
            opb_q   <= sub ? ~b : b;
            carry_q <= sub;
            cnt_q   <= '0;
            sum_q   <= '0;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy    = (state_q == ST_RUN);
  assign s_valid = busy & en;
  assign s_digit = busy ? dsum : '0;
  assign done    = (state_q == ST_DONE);
  assign sum     = sum_q;
  assign cout    = cout_q;
  assign ovf     = ovf_q;

endmodule
